// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   NUM_DIGITS_DEF : default digit count of the display
//   SEG_OFF        : active-low segment pattern with every segment dark
//   ST_OFF/ST_SCAN : scan FSM state codes (state_t)
//   GLYPH          : active-low {g,f,e,d,c,b,a} pattern for each hex nibble
package seg_pkg;

  localparam int NUM_DIGITS_DEF = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef logic [0:0] state_t;
  localparam state_t ST_OFF  = 1'b0;
  localparam state_t ST_SCAN = 1'b1;

  localparam logic [6:0] GLYPH [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    return GLYPH[nib];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bus between a host (CPU debug logic) and the 7-segment scan controller.
//   en, load, data, dp_mask, digit_mask : host -> controller
//   an, seg, frame_start, pending        : controller -> host/board pins
//   dbg_state                            : controller FSM state, for observation
// Handshake: load is a one-cycle strobe with no ready; the controller
// always accepts it in the cycle it is high and the newest load wins.
interface seg_scan_ctrl_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   digit_mask;
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              seg;
  logic                    frame_start;
  logic                    pending;
  state_t                  dbg_state;

  modport master (
    output en, load, data, dp_mask, digit_mask,
    input  an, seg, frame_start, pending, dbg_state
  );

  modport slave (
    input  en, load, data, dp_mask, digit_mask,
    output an, seg, frame_start, pending, dbg_state
  );
endinterface

// File: rtl/seg_scan_ctrl_tick.sv
// Slot/digit timebase for the scan controller.
//   clk, rst_n : clock, synchronous active-low reset
//   run        : 1 = advance; 0 = hold both counters at 0
//   idx        : digit currently owning the display
//   commit     : first cycle of a frame (digit 0, slot position 0) while running
//   blank      : inside the anti-ghost gap at the start of a slot
module seg_scan_tick
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int DIV        = 100000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  output logic [$clog2(NUM_DIGITS)-1:0] idx,
  output logic                          commit,
  output logic                          blank
);
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] slot_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  assign commit = run && (slot_cnt == '0) && (idx == '0);
  assign blank  = 32'(slot_cnt) < 32'(BLANK_CYC);
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Holds a pending value until the next frame boundary so a frame never
// mixes two values, blanks between digits, and suppresses leading zeros.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : seg_scan_ctrl_if slave (controls in, an/seg/status out)
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int DIV        = 100000,
  parameter int BLANK_CYC  = 16,
  parameter bit LZ_BLANK   = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);

  state_t                  state;
  logic                    run, commit, blank;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend, disp;
  logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
  logic                    pending;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [7:0]              seg_q;
  logic                    frame_start_q;

  // Counters only run while scanning and enabled, so dropping en clears
  // them in the same edge that returns the FSM to OFF.
  assign run = (state == ST_SCAN) && bus.en;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_OFF;
    else        state <= bus.en ? ST_SCAN : ST_OFF;
  end

  seg_scan_tick #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIV        (DIV),
    .BLANK_CYC  (BLANK_CYC)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .idx    (idx),
    .commit (commit),
    .blank  (blank)
  );

  // The commit copies the old pend; a load in the same cycle refills pend
  // and keeps pending set for the following frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend    <= '0;
      pend_dp <= '0;
      disp    <= '0;
      disp_dp <= '0;
      pending <= 1'b0;
    end else begin
      if (commit && pending) begin
        disp    <= pend;
        disp_dp <= pend_dp;
      end
      if (bus.load) begin
        pend    <= bus.data;
        pend_dp <= bus.dp_mask;
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  logic [3:0]            nib;
  logic                  dp_bit, lz, dark;
  logic [NUM_DIGITS-1:0] an_d;
  logic [7:0]            seg_d;

  always_comb begin
    nib    = disp[4*idx +: 4];
    dp_bit = disp_dp[idx];
    // Leading zero: this nibble and every more-significant one are zero.
    lz     = LZ_BLANK && (idx != '0) && ((disp >> {idx, 2'b00}) == '0);
    dark   = !run || blank || !bus.digit_mask[idx] || lz;
    an_d   = ~(NUM_DIGITS'(1) << idx);
    seg_d  = {~dp_bit, glyph(nib)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q          <= '1;
      seg_q         <= SEG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= commit;
      an_q          <= dark ? '1 : an_d;
      seg_q         <= dark ? SEG_OFF : seg_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame_start = frame_start_q;
  assign bus.pending     = pending;
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
  localparam int ND    = 8;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = ND * DIV;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) ifc();

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .DIV        (DIV),
    .BLANK_CYC  (BLANK),
    .LZ_BLANK   (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // reference model: one frame-position counter m_t (0..FRAME-1)
  bit          m_scan;
  int          m_t;
  logic [31:0] m_pend, m_disp;
  logic [7:0]  m_pend_dp, m_disp_dp;
  bit          m_pending;
  logic [7:0]  e_an, e_seg;
  bit          e_fs;

  // anode-change gap tracking
  logic [7:0] last_an;
  bit         have_last = 1'b0;
  int         ff_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Advance the model across the coming edge using the inputs now applied.
  task automatic model_step();
    int slot, dig;
    bit run, dark, commit;
    logic [3:0] nib;
    if (!rst_n) begin
      m_scan = 0; m_t = 0; m_pending = 0;
      m_pend = '0; m_pend_dp = '0; m_disp = '0; m_disp_dp = '0;
      e_an = 8'hFF; e_seg = 8'hFF; e_fs = 0;
      return;
    end
    run    = m_scan && ifc.en;
    slot   = m_t % DIV;
    dig    = m_t / DIV;
    nib    = 4'((m_disp >> (4 * dig)) & 32'hF);
    dark   = !run || (slot < BLANK) || !ifc.digit_mask[dig] ||
             (dig != 0 && (m_disp >> (4 * dig)) == 32'h0);
    e_an   = dark ? 8'hFF : ~(8'h01 << dig);
    e_seg  = dark ? 8'hFF : {~m_disp_dp[dig], glyph_tab[nib]};
    commit = run && (m_t == 0);
    e_fs   = commit;
    if (commit && m_pending) begin
      m_disp    = m_pend;
      m_disp_dp = m_pend_dp;
    end
    if (ifc.load) begin
      m_pend = ifc.data; m_pend_dp = ifc.dp_mask; m_pending = 1;
    end else if (commit) begin
      m_pending = 0;
    end
    m_t    = run ? (m_t + 1) % FRAME : 0;
    m_scan = ifc.en;
  endtask

  // One clock: model, edge, then compare everything 1 time unit later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("an", ifc.an, e_an);
    chk("seg", ifc.seg, e_seg);
    chk("frame_start", ifc.frame_start, e_fs);
    chk("pending", ifc.pending, m_pending);
    chk("an_onehot", 32'($countones(~ifc.an) <= 1), 1);
    if (ifc.an != 8'hFF) begin
      if (have_last && ifc.an != last_an) chk("an_gap", 32'(ff_run >= BLANK), 1);
      last_an = ifc.an; have_last = 1; ff_run = 0;
    end else begin
      ff_run++;
    end
  endtask

  task automatic wait_frame();
    bit ok = 0;
    for (int i = 0; i < FRAME + 8; i++) begin
      tick();
      if (ifc.frame_start) begin
        ok = 1;
        break;
      end
    end
    chk("frame_timeout", 32'(ok), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ifc.en = 1'b0; ifc.load = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  dm;
    logic [63:0] exp_seg;  // byte i = seg in digit i's active window, FF = dark
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [7:0] exp_s, exp_a;
    ifc.en = 1'b0; ifc.load = 1'b0; ifc.data = '0;
    ifc.dp_mask = '0; ifc.digit_mask = 8'hFF;

    vecs[0] = '{32'h0000_00A5, 8'h00, 8'hFF, 64'hFFFF_FFFF_FFFF_8892};
    vecs[1] = '{32'h8765_4321, 8'h00, 8'hFF, 64'h80F8_8292_99B0_A4F9};
    vecs[2] = '{32'h0000_0000, 8'h01, 8'hFB, 64'hFFFF_FFFF_FFFF_FF40};
    vecs[3] = '{32'h0000_0300, 8'h01, 8'hFB, 64'hFFFF_FFFF_FFFF_C040};
    vecs[4] = '{32'hDEAD_BEEF, 8'hA0, 8'hFF, 64'h2186_08A1_8386_868E};
    vecs[5] = '{32'h1000_0000, 8'h00, 8'hFF, 64'hF9C0_C0C0_C0C0_C0C0};
    vecs[6] = '{32'h0000_0000, 8'h80, 8'hFF, 64'hFFFF_FFFF_FFFF_FFC0};
    vecs[7] = '{32'h1234_5678, 8'hFF, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF};

    // reset, then disabled for 20 cycles: dark, no pulses
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("off_an", ifc.an, 8'hFF);
    end

    // table: load + enable together, check each digit's active window
    foreach (vecs[v]) begin
      do_reset();
      ifc.data = vecs[v].data; ifc.dp_mask = vecs[v].dp; ifc.digit_mask = vecs[v].dm;
      ifc.en = 1'b1; ifc.load = 1'b1;
      tick();
      ifc.load = 1'b0;
      for (int n = 1; n <= FRAME; n++) begin
        tick();
        if (n % DIV == 6) begin
          exp_s = vecs[v].exp_seg[8 * (n / DIV) +: 8];
          exp_a = (exp_s == 8'hFF) ? 8'hFF : ~(8'h01 << (n / DIV));
          chk("tbl_seg", ifc.seg, exp_s);
          chk("tbl_an", ifc.an, exp_a);
        end
      end
    end
    ifc.digit_mask = 8'hFF; ifc.dp_mask = 8'h00;

    // two loads mid-frame: only the last one is shown next frame
    do_reset();
    ifc.data = 32'h0000_00A5; ifc.en = 1'b1; ifc.load = 1'b1;
    tick();
    ifc.load = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    ifc.load = 1'b1; ifc.data = 32'h1234_5678;
    tick();
    ifc.data = 32'h8765_4321;
    tick();
    ifc.load = 1'b0;
    chk("seq_pending_set", ifc.pending, 1);
    wait_frame();
    chk("seq_pending_clr", ifc.pending, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("seq_d0_seg", ifc.seg, 8'hF9);
    chk("seq_d0_an", ifc.an, 8'hFE);
    for (int i = 0; i < 56; i++) tick();
    chk("seq_d7_seg", ifc.seg, 8'h80);
    chk("seq_d7_an", ifc.an, 8'h7F);

    // reset in slot 5 with a value pending: discarded, display restarts at 0
    wait_frame();
    ifc.load = 1'b1; ifc.data = 32'h0000_0042;
    tick();
    ifc.load = 1'b0;
    chk("rst_pending_before", ifc.pending, 1);
    for (int i = 0; i < 42; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_an", ifc.an, 8'hFF);
    chk("rst_pending", ifc.pending, 0);
    for (int i = 0; i < 7; i++) tick();
    chk("rst_d0_seg", ifc.seg, 8'hC0);
    chk("rst_d0_an", ifc.an, 8'hFE);

    // randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      ifc.load = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        ifc.load = 1'b1;
        ifc.data = $urandom >> (4 * $urandom_range(0, 7));
        ifc.dp_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      end
      if ($urandom_range(0, 63) == 0)
        ifc.digit_mask = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'hFF;
      if (ifc.en && $urandom_range(0, 299) == 0) ifc.en = 1'b0;
      else if (!ifc.en && $urandom_range(0, 9) == 0) ifc.en = 1'b1;
      rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
